// File: rtl/fifo_sync_flex_pkg.sv
// fifo_pkg: shared widths and command encoding for fifo_sync_flex and its pointers
package fifo_pkg;
   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_PUSH = 2'b01,
      CMD_POP  = 2'b10,
      CMD_BOTH = 2'b11
   } cmd_t;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int addr_w(input int depth);
      return $clog2(depth) > 1 ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer that wraps explicitly from DEPTH-1 to 0
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one
//   clr        : return to 0 (wins over inc)
//   ptr        : current pointer value
module fifo_wrap_ptr
   import fifo_pkg::*;
#(
   parameter int DEPTH = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       inc,
   input  logic                       clr,
   output logic [addr_w(DEPTH)-1:0]   ptr
);
   localparam int AW = addr_w(DEPTH);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (clr) ptr <= '0;
      else if (inc) ptr <= ptr == AW'(DEPTH - 1) ? '0 : ptr + AW'(1);
endmodule

// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: synchronous FWFT FIFO of any depth with thresholds, flush and optional peak monitor
//   clk, rst_n                     : clock, asynchronous active-low reset
//   flush                          : synchronous clear, wins over push/pop
//   in_valid/in_ready/in_data      : producer side
//   out_valid/out_ready/out_data   : consumer side, out_data shows the head entry
//   full/empty/almost_full/almost_empty/count : occupancy status from the count register
//   hwm                            : peak occupancy; live only with FIFO_SYNC_FLEX_HWM_EN defined, else 0
module fifo_sync_flex
   import fifo_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 12,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic [cnt_w(DEPTH)-1:0]   hwm
);
   localparam int CW = cnt_w(DEPTH);
   localparam int AW = addr_w(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;
   cmd_t             cmd;
   // handshakes depend only on the count register, so no ready->ready path exists
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign cmd       = cmd_t'({pop, push});
   always_comb
      count_next = flush ? '0 :
                   cmd == CMD_PUSH ? count + CW'(1) :
                   cmd == CMD_POP  ? count - CW'(1) : count;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else count <= count_next;
   assign full         = count == CW'(DEPTH);
   assign empty        = count == '0;
   assign almost_full  = count >= CW'(AFULL_THRESH);
   assign almost_empty = count <= CW'(AEMPTY_THRESH);
   always_ff @(posedge clk)
      if (push && !flush) mem[wptr] <= in_data;
   assign out_data = mem[rptr];
   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push && !flush),
      .clr   (flush),
      .ptr   (wptr)
   );
   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop && !flush),
      .clr   (flush),
      .ptr   (rptr)
   );
`ifdef FIFO_SYNC_FLEX_HWM_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hwm <= '0;
      else if (count_next > hwm) hwm <= count_next;
`else
   assign hwm = '0;
`endif
endmodule

// File: tb/tb_fifo_sync_flex.sv
// tb_fifo_sync_flex: directed and table-driven checks of fifo_sync_flex at DEPTH=12
module tb_fifo_sync_flex;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        full, empty, almost_full, almost_empty;
   logic [3:0]  count, hwm;

   fifo_sync_flex #(.WIDTH(32), .DEPTH(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .hwm          (hwm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic [3:0]  cnt;
      logic [31:0] head;
      logic        f;
      logic        af;
      logic        ae;
   } vec_t;

   vec_t        vecs [25];
   logic [31:0] q [$];
   int          peak;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          npush;
   logic        did_push;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_hwm();
`ifdef FIFO_SYNC_FLEX_HWM_EN
      return 4'(peak);
`else
      return 4'd0;
`endif
   endfunction

   task automatic check_reset_vals();
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_almost_empty", 32'(almost_empty), 1);
      check("rst_almost_full", 32'(almost_full), 0);
      check("rst_hwm", 32'(hwm), 0);
   endtask

   // one cycle against the queue model; called at posedge+1, returns at posedge+1
   task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
      logic p_push, p_pop;
      in_valid = v; in_data = d; out_ready = r; flush = f;
      #1;
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(q.size() != 12));
      p_push = v && q.size() != 12;
      p_pop = r && q.size() != 0;
      if (p_pop) check("head", out_data, q[0]);
      @(posedge clk);
      #1;
      if (f) q.delete();
      else begin
         if (p_pop) void'(q.pop_front());
         if (p_push) q.push_back(d);
      end
      if (q.size() > peak) peak = q.size();
      did_push = p_push && !f;
      check("count", 32'(count), 32'(q.size()));
      check("count_le_depth", 32'(count <= 4'd12), 1);
      check("hwm", 32'(hwm), 32'(exp_hwm()));
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 12; i++)
         vecs[i] = '{v: 1'b1, d: 32'(i), r: 1'b0, cnt: 4'(i + 1), head: 32'h0,
                     f: i == 11, af: i + 1 >= 10, ae: i + 1 <= 1};
      vecs[12] = '{v: 1'b1, d: 32'hEE, r: 1'b0, cnt: 4'd12, head: 32'h0, f: 1'b1, af: 1'b1, ae: 1'b0};
      for (int k = 1; k <= 12; k++)
         vecs[12 + k] = '{v: 1'b0, d: 32'h0, r: 1'b1, cnt: 4'(12 - k), head: 32'(k),
                          f: 1'b0, af: 12 - k >= 10, ae: 12 - k <= 1};

      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fill to full, refuse a 13th push, then drain one word per cycle
      for (int i = 0; i < 25; i++) begin
         in_valid = vecs[i].v; in_data = vecs[i].d; out_ready = vecs[i].r;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         check($sformatf("tbl%0d_full", i), 32'(full), 32'(vecs[i].f));
         check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(!vecs[i].f));
         check($sformatf("tbl%0d_almost_full", i), 32'(almost_full), 32'(vecs[i].af));
         check($sformatf("tbl%0d_almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
         check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
         if (vecs[i].cnt != 0) check($sformatf("tbl%0d_head", i), out_data, vecs[i].head);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      peak = 12;

      // random interleave across the pointer wrap
      npush = 0;
      for (int c = 0; c < 400 && npush < 30; c++) begin
         step(1'($urandom_range(0, 1)), 32'h100 + 32'(npush), 1'($urandom_range(0, 1)), 1'b0);
         if (did_push) npush++;
      end
      check("wrap_push_budget", 32'(npush >= 30), 1);

      // settle at count 5, then 20 cycles of simultaneous push+pop
      for (int c = 0; c < 20 && q.size() != 5; c++)
         step(q.size() < 5, 32'h200 + 32'(c), q.size() > 5, 1'b0);
      check("reach_5", 32'(q.size()), 5);
      for (int c = 0; c < 20; c++) begin
         step(1'b1, 32'h300 + 32'(c), 1'b1, 1'b0);
         check("steady_count", 32'(count), 5);
      end

      // flush at count 7 with a push in the same cycle
      for (int c = 0; c < 2; c++) step(1'b1, 32'h400 + 32'(c), 1'b0, 1'b0);
      check("pre_flush_count", 32'(count), 7);
      step(1'b1, 32'hDEAD, 1'b0, 1'b1);
      check("flush_empty", 32'(empty), 1);
      check("flush_in_ready", 32'(in_ready), 1);
      step(1'b1, 32'h11, 1'b0, 1'b0);
      check("post_flush_head", out_data, 32'h11);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check("post_flush_empty", 32'(empty), 1);

      // asynchronous reset mid-stream at count 4
      for (int c = 0; c < 4; c++) step(1'b1, 32'h500 + 32'(c), 1'b0, 1'b0);
      check("pre_rst_count", 32'(count), 4);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      q.delete();
      peak = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 32'hA5, 1'b0, 1'b0);
      check("rst_push_valid", 32'(out_valid), 1);
      check("rst_push_data", out_data, 32'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
